// File: rtl/dcache_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_responder_pkg
//  Description : Shared types for the data-cache responder. Holds the word
//                type, the cache frame layout, the byte-address split and
//                the controller state encoding.
//                DCACHE_HITCOUNT_EN adds the CNT state (hit-count store).
//  Revision    : 1.0  initial release
// ============================================================================
package dcache_responder_pkg;

   // Geometry. The frame/address structs are sized from DC_SETS, so the
   // top-level SETS parameter must be left equal to DC_SETS.
   localparam int DC_SETS = 8;
   localparam int DC_IDXW = $clog2(DC_SETS);
   localparam int DC_TAGW = 32 - DC_IDXW - 3;

   typedef logic [31:0] word_t;

   // One direct-mapped frame holding a 2-word block.
   typedef struct packed {
      logic               valid;
      logic               dirty;
      logic [DC_TAGW-1:0] tag;
      word_t [1:0]        data;
   } dcache_frame_t;

   // Byte address split: {tag, idx, blkoff, bytoff}.
   typedef struct packed {
      logic [DC_TAGW-1:0] tag;
      logic [DC_IDXW-1:0] idx;
      logic               blkoff;
      logic [1:0]         bytoff;
   } dcachef_t;

   typedef enum logic [3:0] {
      S_COMPARE = 4'd0,
      S_WB0     = 4'd1,
      S_WB1     = 4'd2,
      S_LD0     = 4'd3,
      S_LD1     = 4'd4,
      S_FLUSH   = 4'd5,
      S_FWB0    = 4'd6,
      S_FWB1    = 4'd7,
`ifdef DCACHE_HITCOUNT_EN
      S_CNT     = 4'd8,
`endif
      S_DONE    = 4'd9
   } dstate_t;

endpackage
`default_nettype wire

// File: rtl/dcache_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_responder_if
//  Description : Bundle of the datapath request port and the memory
//                controller port seen by the data-cache responder.
//                slave  : the cache (answers datapath, issues memory requests)
//                master : the environment (datapath + memory controller)
//  Signals     : halt, dmemREN, dmemWEN, dmemaddr, dmemstore -> cache
//                dhit, dmemload, flushed                    <- cache
//                dREN, dWEN, daddr, dstore                  <- cache
//                dwait, dload                               -> cache
//  Revision    : 1.0  initial release
// ============================================================================
interface dcache_responder_if;
   import dcache_responder_pkg::*;

   logic  halt;
   logic  dmemREN;
   logic  dmemWEN;
   word_t dmemaddr;
   word_t dmemstore;
   logic  dhit;
   word_t dmemload;
   logic  flushed;
   logic  dREN;
   logic  dWEN;
   word_t daddr;
   word_t dstore;
   logic  dwait;
   word_t dload;

   modport slave (
      input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
      output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
   );

   modport master (
      output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
      input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
   );

endinterface
`default_nettype wire

// File: rtl/dcache_responder_frame_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_frame_array
//  Description : SETS cache frames with one combinational read port and one
//                whole-frame write port sharing the same index. Valid and
//                dirty bits are cleared synchronously while nRST is low.
//  Ports       : CLK        clock
//                nRST       synchronous active-low clear of valid/dirty
//                idx_i      frame index for read and write
//                rd_frame_o frame at idx_i (combinational)
//                we_i       write enable
//                wr_frame_i frame written at idx_i on the rising edge
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_frame_array
   import dcache_responder_pkg::*;
#(
   parameter int SETS = DC_SETS
) (
   input  wire logic              CLK,
   input  wire logic              nRST,
   input  wire logic [$clog2(SETS)-1:0] idx_i,
   output dcache_frame_t          rd_frame_o,
   input  wire logic              we_i,
   input  dcache_frame_t          wr_frame_i
);

   dcache_frame_t frames_q [SETS];

   assign rd_frame_o = frames_q[idx_i];

   // Tag and data are left as-is on reset; an invalid frame never hits.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < SETS; i++) begin
            frames_q[i].valid <= 1'b0;
            frames_q[i].dirty <= 1'b0;
         end
      end else if (we_i) begin
         frames_q[idx_i] <= wr_frame_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_responder
//  Description : Direct-mapped, write-back, write-allocate data cache with
//                2-word blocks. Serves datapath loads/stores with dhit,
//                refills/evicts through the memory controller port, and on
//                halt writes back every dirty block before raising flushed.
//                Optional DCACHE_HITCOUNT_EN: keeps saturating hit and miss
//                counters and stores (hits - misses) to CNT_ADDR after flush.
//  Ports       : CLK   clock
//                nRST  synchronous active-low reset
//                bus   dcache_responder_if.slave (datapath + memory port)
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_responder
   import dcache_responder_pkg::*;
#(
   parameter int          SETS     = DC_SETS,
   parameter logic [31:0] CNT_ADDR = 32'h3100
) (
   input  wire logic         CLK,
   input  wire logic         nRST,
   dcache_responder_if.slave bus
);

   dstate_t              state_q, state_d;
   logic [DC_IDXW-1:0]   ptr_q, ptr_d;
   word_t                miss_addr_q, miss_addr_d;

   dcachef_t             w_req_a;
   dcachef_t             w_miss_a;
   logic [DC_IDXW-1:0]   w_rd_idx;
   dcache_frame_t        w_rd_frame;
   logic                 w_we;
   dcache_frame_t        w_wr_frame;
   logic                 w_unused_bits;

`ifdef DCACHE_HITCOUNT_EN
   localparam dstate_t S_FLUSH_END = S_CNT;
`else
   localparam dstate_t S_FLUSH_END = S_DONE;
`endif

   assign w_req_a  = bus.dmemaddr;
   assign w_miss_a = miss_addr_q;
   // Both refill words are fetched and byte lanes are ignored.
   assign w_unused_bits = ^{w_req_a.bytoff, w_miss_a.blkoff, w_miss_a.bytoff};

   // The single array port follows whichever set the current state owns.
   always_comb begin
      w_rd_idx = w_miss_a.idx;
      case (state_q)
         S_COMPARE:                 w_rd_idx = w_req_a.idx;
         S_FLUSH, S_FWB0, S_FWB1:   w_rd_idx = ptr_q;
         default:                   w_rd_idx = w_miss_a.idx;
      endcase
   end

   dcache_frame_array #(
      .SETS       (SETS)
   ) u_frames (
      .CLK        (CLK),
      .nRST       (nRST),
      .idx_i      (w_rd_idx),
      .rd_frame_o (w_rd_frame),
      .we_i       (w_we),
      .wr_frame_i (w_wr_frame)
   );

`ifdef DCACHE_HITCOUNT_EN
   word_t hits_q;
   word_t misses_q;
   logic  w_miss_evt;

   assign w_miss_evt = (state_q == S_COMPARE) &&
                       ((state_d == S_WB0) || (state_d == S_LD0));

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         if (bus.dhit && (hits_q != '1))
            hits_q <= hits_q + 1'b1;
         if (w_miss_evt && (misses_q != '1))
            misses_q <= misses_q + 1'b1;
      end
   end
`else
   logic w_unused_cnt_addr;
   assign w_unused_cnt_addr = ^CNT_ADDR;
`endif

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      miss_addr_d  = miss_addr_q;
      w_we         = 1'b0;
      w_wr_frame   = w_rd_frame;
      bus.dhit     = 1'b0;
      bus.dmemload = '0;
      bus.flushed  = 1'b0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;

      case (state_q)
         S_COMPARE: begin
            // halt wins over a same-cycle request: the datapath has stopped.
            if (bus.halt) begin
               state_d = S_FLUSH;
               ptr_d   = '0;
            end else if (bus.dmemREN || bus.dmemWEN) begin
               if (w_rd_frame.valid && (w_rd_frame.tag == w_req_a.tag)) begin
                  bus.dhit = 1'b1;
                  if (bus.dmemREN)
                     bus.dmemload = w_rd_frame.data[w_req_a.blkoff];
                  if (bus.dmemWEN) begin
                     w_we                              = 1'b1;
                     w_wr_frame.dirty                  = 1'b1;
                     w_wr_frame.data[w_req_a.blkoff]   = bus.dmemstore;
                  end
               end else begin
                  // Latch the address so the fill survives a withdrawn request.
                  miss_addr_d = bus.dmemaddr;
                  state_d     = (w_rd_frame.valid && w_rd_frame.dirty) ? S_WB0 : S_LD0;
               end
            end
         end

         S_WB0: begin
            bus.dWEN   = 1'b1;
            bus.daddr  = {w_rd_frame.tag, w_miss_a.idx, 1'b0, 2'b00};
            bus.dstore = w_rd_frame.data[0];
            if (!bus.dwait) state_d = S_WB1;
         end

         S_WB1: begin
            bus.dWEN   = 1'b1;
            bus.daddr  = {w_rd_frame.tag, w_miss_a.idx, 1'b1, 2'b00};
            bus.dstore = w_rd_frame.data[1];
            if (!bus.dwait) state_d = S_LD0;
         end

         S_LD0: begin
            bus.dREN  = 1'b1;
            bus.daddr = {w_miss_a.tag, w_miss_a.idx, 1'b0, 2'b00};
            if (!bus.dwait) begin
               // Frame is half-old/half-new until LD1 lands: keep it invalid.
               w_we               = 1'b1;
               w_wr_frame.valid   = 1'b0;
               w_wr_frame.dirty   = 1'b0;
               w_wr_frame.data[0] = bus.dload;
               state_d            = S_LD1;
            end
         end

         S_LD1: begin
            bus.dREN  = 1'b1;
            bus.daddr = {w_miss_a.tag, w_miss_a.idx, 1'b1, 2'b00};
            if (!bus.dwait) begin
               w_we               = 1'b1;
               w_wr_frame.valid   = 1'b1;
               w_wr_frame.dirty   = 1'b0;
               w_wr_frame.tag     = w_miss_a.tag;
               w_wr_frame.data[1] = bus.dload;
               state_d            = S_COMPARE;
            end
         end

         S_FLUSH: begin
            if (w_rd_frame.valid && w_rd_frame.dirty)
               state_d = S_FWB0;
            else if (ptr_q == DC_IDXW'(SETS - 1))
               state_d = S_FLUSH_END;
            else
               ptr_d = ptr_q + 1'b1;
         end

         S_FWB0: begin
            bus.dWEN   = 1'b1;
            bus.daddr  = {w_rd_frame.tag, ptr_q, 1'b0, 2'b00};
            bus.dstore = w_rd_frame.data[0];
            if (!bus.dwait) state_d = S_FWB1;
         end

         S_FWB1: begin
            bus.dWEN   = 1'b1;
            bus.daddr  = {w_rd_frame.tag, ptr_q, 1'b1, 2'b00};
            bus.dstore = w_rd_frame.data[1];
            if (!bus.dwait) begin
               w_we             = 1'b1;
               w_wr_frame.dirty = 1'b0;
               if (ptr_q == DC_IDXW'(SETS - 1)) begin
                  state_d = S_FLUSH_END;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = S_FLUSH;
               end
            end
         end

`ifdef DCACHE_HITCOUNT_EN
         S_CNT: begin
            bus.dWEN   = 1'b1;
            bus.daddr  = CNT_ADDR;
            bus.dstore = hits_q - misses_q;
            if (!bus.dwait) state_d = S_DONE;
         end
`endif

         S_DONE: begin
            bus.flushed = 1'b1;
         end

         default: begin
            state_d = S_COMPARE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= S_COMPARE;
         ptr_q       <= '0;
         miss_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         miss_addr_q <= miss_addr_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_responder
//  Description : Directed testbench for dcache_responder: cold fill, store
//                hit, dirty eviction, slow memory, reset during refill,
//                flush of dirty sets and (DCACHE_HITCOUNT_EN) count store.
//                Memory words not yet written read as 0xA000_0000 | address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_responder;
   import dcache_responder_pkg::*;

   logic  CLK = 1'b0;
   logic  nRST;
   int    checks = 0;
   int    errors = 0;
   int    lat    = 0;
   int    hits   = 0;
   int    misses = 0;
   int    n0;
   logic [3:0] wcnt      = '0;
   logic       init_done = 1'b0;
   word_t mem [4096];
   word_t wr_addr_q [$];
   word_t wr_data_q [$];
   word_t exp_a [5];
   word_t exp_d [5];

`ifdef DCACHE_HITCOUNT_EN
   localparam int N_EXP = 5;
`else
   localparam int N_EXP = 4;
`endif

   dcache_responder_if bus ();

   dcache_responder #(
      .SETS     (8),
      .CNT_ADDR (32'h3100)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   // Memory controller: each word stalls for 'lat' cycles of dwait=1.
   assign bus.dwait = (bus.dREN || bus.dWEN) && (int'(wcnt) < lat);
   assign bus.dload = mem[bus.daddr[13:2]];

   always @(posedge CLK) begin
      if (!init_done) begin
         for (int i = 0; i < 4096; i++)
            mem[i] <= 32'hA000_0000 | 32'(i << 2);
         init_done <= 1'b1;
      end else begin
         if ((bus.dREN || bus.dWEN) && bus.dwait)
            wcnt <= wcnt + 4'd1;
         else
            wcnt <= '0;
         if (bus.dWEN && !bus.dwait) begin
            mem[bus.daddr[13:2]] <= bus.dstore;
            wr_addr_q.push_back(bus.daddr);
            wr_data_q.push_back(bus.dstore);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic ren, input logic wen, input word_t a, input word_t d);
      @(negedge CLK);
      bus.dmemREN   = ren;
      bus.dmemWEN   = wen;
      bus.dmemaddr  = a;
      bus.dmemstore = d;
      #1;
   endtask

   task automatic tick;
      @(negedge CLK);
      #1;
   endtask

   initial begin
      nRST          = 1'b0;
      bus.halt      = 1'b0;
      bus.dmemREN   = 1'b0;
      bus.dmemWEN   = 1'b0;
      bus.dmemaddr  = '0;
      bus.dmemstore = '0;

      // ---------------- reset state
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_dhit",     bus.dhit,     1'b0);
      chk("rst_flushed",  bus.flushed,  1'b0);
      chk("rst_dREN",     bus.dREN,     1'b0);
      chk("rst_dWEN",     bus.dWEN,     1'b0);
      chk("rst_daddr",    bus.daddr,    32'h0);
      chk("rst_dstore",   bus.dstore,   32'h0);
      chk("rst_dmemload", bus.dmemload, 32'h0);
      nRST = 1'b1;

      // ---------------- cold load 0x40, zero-wait memory
      req(1'b1, 1'b0, 32'h40, 32'h0);
      chk("cold_miss_dhit", bus.dhit, 1'b0);
      chk("cold_cmp_noreq", bus.dREN, 1'b0);
      tick();
      chk("cold_ld0_dREN",  bus.dREN,  1'b1);
      chk("cold_ld0_daddr", bus.daddr, 32'h40);
      chk("cold_ld0_dhit",  bus.dhit,  1'b0);
      tick();
      chk("cold_ld1_daddr", bus.daddr, 32'h44);
      tick();
      chk("cold_hit",      bus.dhit,     1'b1);
      chk("cold_load",     bus.dmemload, 32'hA000_0040);
      chk("cold_hit_dREN", bus.dREN,     1'b0);

      // ---------------- store hit, then read it back
      req(1'b0, 1'b1, 32'h40, 32'h0000_DEAD);
      chk("st_hit",  bus.dhit, 1'b1);
      chk("st_dWEN", bus.dWEN, 1'b0);
      req(1'b1, 1'b0, 32'h40, 32'h0);
      chk("st_readback", bus.dmemload, 32'h0000_DEAD);

      // ---------------- conflict miss 0x240 evicts dirty block 0x40
      req(1'b1, 1'b0, 32'h240, 32'h0);
      chk("ev_miss_dhit", bus.dhit, 1'b0);
      tick();
      chk("ev_wb0_dWEN",   bus.dWEN,   1'b1);
      chk("ev_wb0_daddr",  bus.daddr,  32'h40);
      chk("ev_wb0_dstore", bus.dstore, 32'h0000_DEAD);
      tick();
      chk("ev_wb1_daddr",  bus.daddr,  32'h44);
      chk("ev_wb1_dstore", bus.dstore, 32'hA000_0044);
      tick();
      chk("ev_ld0_dREN",  bus.dREN,  1'b1);
      chk("ev_ld0_daddr", bus.daddr, 32'h240);
      tick();
      chk("ev_ld1_daddr", bus.daddr, 32'h244);
      tick();
      chk("ev_hit",  bus.dhit,     1'b1);
      chk("ev_load", bus.dmemload, 32'hA000_0240);
      chk("ev_mem_wb", mem[32'h40 >> 2], 32'h0000_DEAD);

      // ---------------- slow memory: 3 wait cycles per word, clean victim
      lat = 3;
      req(1'b1, 1'b0, 32'h80, 32'h0);
      chk("slow_miss_dhit", bus.dhit, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("slow_ld0_dREN",  bus.dREN,  1'b1);
         chk("slow_ld0_daddr", bus.daddr, 32'h80);
         chk("slow_ld0_dWEN",  bus.dWEN,  1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("slow_ld1_daddr", bus.daddr, 32'h84);
      end
      tick();
      chk("slow_hit",  bus.dhit,     1'b1);
      chk("slow_load", bus.dmemload, 32'hA000_0080);
      lat = 0;

      // ---------------- reset while in LD1 abandons the fill
      req(1'b1, 1'b0, 32'h100, 32'h0);
      tick();
      chk("rfill_ld0_daddr", bus.daddr, 32'h100);
      tick();
      chk("rfill_ld1_daddr", bus.daddr, 32'h104);
      nRST = 1'b0;
      @(negedge CLK);
      nRST          = 1'b1;
      bus.dmemaddr  = 32'h40;
      #1;
      chk("rfill_cmp_dREN", bus.dREN, 1'b0);
      chk("rfill_invalid",  bus.dhit, 1'b0);
      misses++;
      tick();
      chk("rfill_re_ld0", bus.daddr, 32'h40);
      chk("rfill_re_dREN", bus.dREN, 1'b1);
      tick();
      tick();
      chk("rfill_re_hit",  bus.dhit,     1'b1);
      chk("rfill_re_load", bus.dmemload, 32'h0000_DEAD);
      hits++;

      // ---------------- dirty sets 0 and 5, plus extra hits
      req(1'b0, 1'b1, 32'h40, 32'h0000_BEEF);
      chk("d0_hit", bus.dhit, 1'b1);
      hits++;
      req(1'b0, 1'b1, 32'h28, 32'h0000_0055);
      chk("d5_miss", bus.dhit, 1'b0);
      misses++;
      tick();
      chk("d5_ld0", bus.daddr, 32'h28);
      tick();
      chk("d5_ld1", bus.daddr, 32'h2C);
      tick();
      chk("d5_hit", bus.dhit, 1'b1);
      hits++;
      req(1'b1, 1'b0, 32'h44, 32'h0);
      chk("h44_load", bus.dmemload, 32'hA000_0044);
      hits++;
      req(1'b1, 1'b0, 32'h2C, 32'h0);
      chk("h2c_load", bus.dmemload, 32'hA000_002C);
      hits++;

      // ---------------- halt: flush dirty blocks in set order
      exp_a[0] = 32'h40;   exp_d[0] = 32'h0000_BEEF;
      exp_a[1] = 32'h44;   exp_d[1] = 32'hA000_0044;
      exp_a[2] = 32'h28;   exp_d[2] = 32'h0000_0055;
      exp_a[3] = 32'h2C;   exp_d[3] = 32'hA000_002C;
      exp_a[4] = 32'h3100; exp_d[4] = 32'(hits - misses);
      n0 = wr_addr_q.size();
      @(negedge CLK);
      bus.dmemREN = 1'b0;
      bus.dmemWEN = 1'b0;
      bus.halt    = 1'b1;
      #1;
      chk("halt_dhit", bus.dhit, 1'b0);
      for (int k = 0; k < 60; k++) begin
         if (bus.flushed === 1'b1) break;
         tick();
      end
      chk("flush_done", bus.flushed, 1'b1);
      chk("flush_wr_count", 32'(wr_addr_q.size() - n0), 32'(N_EXP));
      for (int i = 0; i < N_EXP; i++) begin
         if (n0 + i < wr_addr_q.size()) begin
            chk("flush_wr_addr", wr_addr_q[n0 + i], exp_a[i]);
            chk("flush_wr_data", wr_data_q[n0 + i], exp_d[i]);
         end
      end

      // ---------------- DONE is sticky and silent even with a hitting request
      bus.dmemREN  = 1'b1;
      bus.dmemaddr = 32'h40;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("done_flushed", bus.flushed, 1'b1);
         chk("done_dhit",    bus.dhit,    1'b0);
         chk("done_dREN",    bus.dREN,    1'b0);
         chk("done_dWEN",    bus.dWEN,    1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
